// File: rtl/batcharger_pkg.sv
// batcharger_pkg: shared definitions for the battery charge controller.
// Holds the charge state encoding, the voltage code scale and the default
// timer widths.
package batcharger_pkg;

  // Charge sequence states; encoding is fixed so the debug port can be
  // decoded by anyone who only has the numeric value.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TC   = 3'd1,
    ST_CC   = 3'd2,
    ST_CV   = 3'd3,
    ST_DONE = 3'd4
  } chg_state_t;

  // Voltage codes: 51 codes per volt (e.g. 153 = 3.0 V, 189 = 3.7 V).
  localparam int VCODE_PER_V = 51;

  // One timer tick every 2^DEF_PRESC_W clocks; timeout counter width.
  localparam int DEF_PRESC_W = 10;
  localparam int DEF_TMR_W   = 8;

endpackage

// File: rtl/batcharger_if.sv
// batcharger_if: signal bundle between the charge controller and its
// environment (measurement front-ends, threshold registers, power stage).
//   master: drives enable, measured codes and thresholds; observes outputs.
//   slave : the controller; samples inputs, drives power-stage/monitor
//           enables, done and the debug state.
// There is no handshake: every input is sampled on every rising clock edge
// and every output is a registered level valid after that edge.
interface batcharger_if
  import batcharger_pkg::*;
#(
  parameter int TMR_W = DEF_TMR_W
);
  logic             en;
  logic [7:0]       vbat;
  logic [7:0]       ibat;
  logic [7:0]       tbat;
  logic [7:0]       vcutoff;
  logic [7:0]       vpreset;
  logic [7:0]       vcv;
  logic [7:0]       iend;
  logic [7:0]       tempmin;
  logic [7:0]       tempmax;
  logic [TMR_W-1:0] tmax;

  logic             cc;
  logic             tc;
  logic             cv;
  logic             pwr_en;
  logic             vmonen;
  logic             imonen;
  logic             tmonen;
  logic             done;
  chg_state_t       dbg_state;

  modport master (
    output en, vbat, ibat, tbat, vcutoff, vpreset, vcv, iend,
           tempmin, tempmax, tmax,
    input  cc, tc, cv, pwr_en, vmonen, imonen, tmonen, done, dbg_state
  );

  modport slave (
    input  en, vbat, ibat, tbat, vcutoff, vpreset, vcv, iend,
           tempmin, tempmax, tmax,
    output cc, tc, cv, pwr_en, vmonen, imonen, tmonen, done, dbg_state
  );
endinterface

// File: rtl/batcharger_timer.sv
// batcharger_timer: CV-phase timeout.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_clr         : clear prescaler and counter (CV entry), wins over i_run
//   i_run         : prescaler advances while high (controller is in CV)
//   i_tmax        : timeout threshold in ticks
//   o_timeout     : combinational; high on a tick where count == i_tmax
// A tick is the cycle in which the prescaler sits at its all-ones value.
// The tick counter saturates at all ones so a long CV phase never wraps.
module batcharger_timer #(
  parameter int PRESC_W = 10,
  parameter int TMR_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [TMR_W-1:0] i_tmax,
  output logic             o_timeout
);
  logic [PRESC_W-1:0] r_presc;
  logic [TMR_W-1:0]   r_cnt;
  logic               w_tick;

  assign w_tick    = i_run && (r_presc == '1);
  // Compared before the increment, so tmax = 0 fires on the first tick.
  assign o_timeout = w_tick && (r_cnt == i_tmax);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_presc <= r_presc + 1'b1;
      if (w_tick && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/batcharger_ctrl.sv
// batcharger_ctrl: trickle / constant-current / constant-voltage charge
// sequencer for the BATCHARGERpower_64b power stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : batcharger_if.slave (enable, vbat/ibat/tbat codes, thresholds,
//              tmax; cc/tc/cv/pwr_en, monitor enables, done, dbg_state)
// Optional feature macro: BATCHARGER_TIMEOUT_EN adds a prescaled timeout
// that also ends the CV phase; without it tmax is ignored.
// Outputs are decoded from the next state and registered, so they change on
// the same edge as the state and never glitch or overlap.
module batcharger_ctrl
  import batcharger_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int TMR_W   = DEF_TMR_W
) (
  input logic         clk,
  input logic         rst,
  batcharger_if.slave bus
);
  chg_state_t r_state;
  chg_state_t w_next;
  logic       w_tok;
  logic       w_timeout;
  logic       w_cv_entry;
  logic       w_charging;

  logic r_tc, r_cc, r_cv, r_pwr_en, r_vmonen, r_imonen, r_tmonen, r_done;

  assign w_tok      = (bus.tbat >= bus.tempmin) && (bus.tbat <= bus.tempmax);
  assign w_cv_entry = (w_next == ST_CV) && (r_state != ST_CV);

`ifdef BATCHARGER_TIMEOUT_EN
  batcharger_timer #(
    .PRESC_W (PRESC_W),
    .TMR_W   (TMR_W)
  ) u_timer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (w_cv_entry),
    .i_run     (r_state == ST_CV),
    .i_tmax    (bus.tmax),
    .o_timeout (w_timeout)
  );
`else
  localparam int UNUSED_PRESC_W = PRESC_W;
  logic [TMR_W-1:0] w_unused_tmax;
  logic             w_unused_entry;
  assign w_unused_tmax  = bus.tmax;
  assign w_unused_entry = w_cv_entry;
  assign w_timeout      = 1'b0;
`endif

  // Next state. Abort (disable or temperature out of window) beats every
  // other transition; at most one transition is taken per clock, so a jump
  // past both vcutoff and vcv from TC lands in CC first.
  always_comb begin
    w_next = r_state;
    if (!bus.en || !w_tok) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.vbat < bus.vcutoff)  w_next = ST_TC;
          else if (bus.vbat < bus.vcv) w_next = ST_CC;
          else                         w_next = ST_DONE;
        end
        ST_TC:   if (bus.vbat >= bus.vcutoff) w_next = ST_CC;
        ST_CC:   if (bus.vbat >= bus.vcv)     w_next = ST_CV;
        ST_CV:   if ((bus.ibat < bus.iend) || w_timeout) w_next = ST_DONE;
        // Recharge re-enters CC, never TC.
        ST_DONE: if (bus.vbat < bus.vpreset)  w_next = ST_CC;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign w_charging = (w_next == ST_TC) || (w_next == ST_CC) || (w_next == ST_CV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tc     <= 1'b0;
      r_cc     <= 1'b0;
      r_cv     <= 1'b0;
      r_pwr_en <= 1'b0;
      r_vmonen <= 1'b0;
      r_imonen <= 1'b0;
      r_tmonen <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_tc     <= (w_next == ST_TC);
      r_cc     <= (w_next == ST_CC);
      r_cv     <= (w_next == ST_CV);
      r_pwr_en <= w_charging;
      r_vmonen <= (w_next != ST_IDLE);
      r_imonen <= w_charging;
      r_tmonen <= bus.en;
      r_done   <= (w_next == ST_DONE);
    end
  end

  assign bus.tc        = r_tc;
  assign bus.cc        = r_cc;
  assign bus.cv        = r_cv;
  assign bus.pwr_en    = r_pwr_en;
  assign bus.vmonen    = r_vmonen;
  assign bus.imonen    = r_imonen;
  assign bus.tmonen    = r_tmonen;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_batcharger_ctrl.sv
// tb_batcharger_ctrl: scoreboard bench for batcharger_ctrl.
// Driver applies inputs at the falling edge and pushes the reference
// model's expected output vector; a monitor compares after each rising edge.
// Output vector order: {tc, cc, cv, pwr_en, vmonen, imonen, tmonen, done}.
module tb_batcharger_ctrl;
  import batcharger_pkg::*;

  localparam int PW = 2;
  localparam int TW = 8;

  localparam int P_IDLE = 0;
  localparam int P_TC   = 1;
  localparam int P_CC   = 2;
  localparam int P_CV   = 3;
  localparam int P_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  batcharger_if #(.TMR_W(TW)) bus();

  batcharger_ctrl #(.PRESC_W(PW), .TMR_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: charge phase and clocks spent in CV since entry.
  int ph     = P_IDLE;
  int cv_clk = 0;

  function automatic logic [7:0] outs_now();
    return {bus.tc, bus.cc, bus.cv, bus.pwr_en, bus.vmonen, bus.imonen,
            bus.tmonen, bus.done};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] expect_outs(input int p, input logic e);
    logic chg;
    chg = (p == P_TC) || (p == P_CC) || (p == P_CV);
    return {p == P_TC, p == P_CC, p == P_CV, chg, p != P_IDLE, chg, e, p == P_DONE};
  endfunction

  // Behavioural rules: one transition per clock, abort first.
  task automatic model_step();
    int  nxt;
    bit  tok;
    bit  tmo;
    int  kk;
    int  c;
    tok = (bus.tbat >= bus.tempmin) && (bus.tbat <= bus.tempmax);
    nxt = ph;
    tmo = 0;
    kk  = cv_clk + 1;
    c   = 0;
`ifdef BATCHARGER_TIMEOUT_EN
    // The kk-th clock in CV is a tick when kk is a multiple of 2^PW; the
    // tick count seen at tick j is j-1, saturating at 2^TW-1.
    if (ph == P_CV && (kk % (1 << PW)) == 0) begin
      c = kk / (1 << PW) - 1;
      if (c > (1 << TW) - 1) c = (1 << TW) - 1;
      tmo = (c == int'(bus.tmax));
    end
`endif
    if (!bus.en || !tok) nxt = P_IDLE;
    else begin
      case (ph)
        P_IDLE: nxt = (bus.vbat < bus.vcutoff) ? P_TC :
                      (bus.vbat < bus.vcv) ? P_CC : P_DONE;
        P_TC:   if (bus.vbat >= bus.vcutoff) nxt = P_CC;
        P_CC:   if (bus.vbat >= bus.vcv) nxt = P_CV;
        P_CV:   if (bus.ibat < bus.iend || tmo) nxt = P_DONE;
        P_DONE: if (bus.vbat < bus.vpreset) nxt = P_CC;
        default: nxt = P_IDLE;
      endcase
    end
    cv_clk = (ph == P_CV && nxt == P_CV) ? kk : 0;
    ph = nxt;
    exp_q.push_back(expect_outs(ph, bus.en));
  endtask

  task automatic apply(input logic e, input logic [7:0] v, input logic [7:0] i,
                       input logic [7:0] t);
    bus.en   = e;
    bus.vbat = v;
    bus.ibat = i;
    bus.tbat = t;
    model_step();
  endtask

  task automatic cyc(input logic e, input logic [7:0] v, input logic [7:0] i,
                     input logic [7:0] t);
    @(negedge clk);
    apply(e, v, i, t);
  endtask

  // Monitor: every rising edge presents a new registered output vector.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check8("outputs", outs_now(), e);
      end
    end
  end

  initial begin
    bus.en      = 1'b1;
    bus.vbat    = 8'd150;
    bus.ibat    = 8'd100;
    bus.tbat    = 8'd100;
    bus.tempmin = 8'd50;
    bus.tempmax = 8'd150;
    bus.vcutoff = 8'd153;
    bus.vcv     = 8'd189;
    bus.vpreset = 8'd179;
    bus.iend    = 8'd10;
    bus.tmax    = TW'(3);

    #1 rst = 1'b1;
    #1 check8("reset_outputs", outs_now(), 8'h00);

    // Full charge.
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 8'd150, 8'd100, 8'd100);
    cyc(1'b1, 8'd150, 8'd100, 8'd100);
    cyc(1'b1, 8'd160, 8'd100, 8'd100);
    cyc(1'b1, 8'd189, 8'd50, 8'd100);
    cyc(1'b1, 8'd190, 8'd50, 8'd100);
    cyc(1'b1, 8'd190, 8'd9, 8'd100);
    cyc(1'b1, 8'd185, 8'd5, 8'd100);
    // Recharge from DONE.
    cyc(1'b1, 8'd178, 8'd5, 8'd100);
    cyc(1'b1, 8'd170, 8'd80, 8'd100);
    // Temperature abort and resume.
    cyc(1'b1, 8'd170, 8'd80, 8'd200);
    cyc(1'b1, 8'd160, 8'd80, 8'd100);
    // Long CV: times out with the feature, holds without it.
    cyc(1'b1, 8'd189, 8'd50, 8'd100);
    for (int n = 0; n < 24; n++) cyc(1'b1, 8'd189, 8'd50, 8'd100);
    cyc(1'b1, 8'd160, 8'd50, 8'd100);
    cyc(1'b1, 8'd189, 8'd50, 8'd100);
    cyc(1'b1, 8'd189, 8'd50, 8'd100);
    // Disable in CV.
    cyc(1'b0, 8'd189, 8'd50, 8'd100);
    cyc(1'b0, 8'd189, 8'd50, 8'd100);
    // Direct jump to DONE from IDLE.
    cyc(1'b1, 8'd200, 8'd50, 8'd100);
    cyc(1'b1, 8'd200, 8'd50, 8'd100);
    // Temperature window edges (inclusive).
    cyc(1'b1, 8'd160, 8'd50, 8'd150);
    cyc(1'b1, 8'd160, 8'd50, 8'd151);
    cyc(1'b1, 8'd160, 8'd50, 8'd50);
    cyc(1'b1, 8'd160, 8'd50, 8'd49);
    cyc(1'b1, 8'd160, 8'd50, 8'd100);

    // Asynchronous reset mid-CC, checked between clock edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1 check8("async_reset", outs_now(), 8'h00);
    ph = P_IDLE;
    cv_clk = 0;
    @(negedge clk);
    rst = 1'b0;
    // TC jumping past both thresholds goes to CC, then CV.
    apply(1'b1, 8'd150, 8'd100, 8'd100);
    cyc(1'b1, 8'd200, 8'd100, 8'd100);
    cyc(1'b1, 8'd200, 8'd100, 8'd100);
    cyc(1'b1, 8'd200, 8'd100, 8'd100);

    // Randomized traffic around the thresholds.
    for (int n = 0; n < 1500; n++) begin
      logic       e;
      logic [7:0] v, i, t;
      int         sel;
      e = ($urandom_range(0, 29) != 0);
      t = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(50, 150));
      sel = $urandom_range(0, 5);
      case (sel)
        0:       v = 8'($urandom_range(0, 255));
        1:       v = 8'($urandom_range(148, 158));
        2:       v = 8'($urandom_range(184, 194));
        3:       v = 8'($urandom_range(175, 183));
        default: v = 8'($urandom_range(150, 200));
      endcase
      i = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(10, 255));
      if ($urandom_range(0, 99) == 0) bus.tmax = TW'($urandom_range(0, 3));
      cyc(e, v, i, t);
    end

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
